// File: rtl/rc4_key_search_ctrl.sv
// RC4 key search sequencer: per key runs init -> shuffle -> decrypt, steps key on decrypt fail.
// Latency: 3 cycles plus 1 (NEXT) per key on top of sub-FSMs; KEY_SEARCH_WDOG_EN adds a per-wait-state timeout.
// Backpressure: none; each wait state holds until its done pulse, abort forces IDLE.
module rc4_key_search_ctrl #(
   parameter int              KEY_W     = 24,
   parameter logic [KEY_W-1:0] KEY_FIRST = '0,
   parameter logic [KEY_W-1:0] KEY_LAST  = 24'h3FFFFF
`ifdef KEY_SEARCH_WDOG_EN
   ,
   parameter int              WDOG_CYC  = 1024
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             init_done,
   input  logic             shuffle_done,
   input  logic             decrypt_done,
   input  logic             fail_sig,
   output logic             init_start,
   output logic             shuffle_start,
   output logic             decrypt_start,
   output logic             sub_rst,
   output logic [1:0]       s_sel,
   output logic [KEY_W-1:0] secret_key,
   output logic [KEY_W-1:0] keys_tried,
   output logic             busy,
   output logic             found,
   output logic             exhausted
);

   typedef enum logic [3:0] {
      IDLE, INIT, W_INIT, SHUF, W_SHUF, DEC, W_DEC, NEXT, FOUND, EXHAUSTED
   } state_t;

   state_t st, nxt;
   logic   abort_q;
   logic   load;
   logic   wdog_hit;

   assign load = start && !abort && (st == IDLE || st == FOUND || st == EXHAUSTED);

`ifdef KEY_SEARCH_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC + 1);
   logic [WDOG_W-1:0] wdog_cnt;
   logic              in_wait;

   assign in_wait  = (st == W_INIT) || (st == W_SHUF) || (st == W_DEC);
   assign wdog_hit = in_wait && (wdog_cnt == WDOG_W'(WDOG_CYC - 1));

   // Cleared in the launch state so the count starts at zero on the first wait cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt <= '0;
      end else if (st == INIT || st == SHUF || st == DEC) begin
         wdog_cnt <= '0;
      end else if (in_wait && !wdog_hit) begin
         wdog_cnt <= wdog_cnt + 1'b1;
      end
   end
`else
   assign wdog_hit = 1'b0;
`endif

   always_comb begin
      nxt = st;
      case (st)
         IDLE, FOUND, EXHAUSTED: if (start) nxt = INIT;
         INIT:   nxt = W_INIT;
         W_INIT: if (init_done) nxt = SHUF;
         SHUF:   nxt = W_SHUF;
         W_SHUF: if (shuffle_done) nxt = DEC;
         DEC:    nxt = W_DEC;
         W_DEC: begin
            if (fail_sig)          nxt = NEXT;
            else if (decrypt_done) nxt = FOUND;
         end
         NEXT:   nxt = (secret_key == KEY_LAST) ? EXHAUSTED : INIT;
         default: nxt = IDLE;
      endcase
      if (wdog_hit) nxt = NEXT;
      if (abort)    nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st            <= IDLE;
         abort_q       <= 1'b0;
         init_start    <= 1'b0;
         shuffle_start <= 1'b0;
         decrypt_start <= 1'b0;
         sub_rst       <= 1'b0;
         s_sel         <= 2'd3;
         busy          <= 1'b0;
         found         <= 1'b0;
         exhausted     <= 1'b0;
         secret_key    <= KEY_FIRST;
         keys_tried    <= '0;
      end else begin
         st            <= nxt;
         abort_q       <= abort;
         init_start    <= (nxt == INIT);
         shuffle_start <= (nxt == SHUF);
         decrypt_start <= (nxt == DEC);
         // A held abort level produces only one sub-FSM reset pulse.
         sub_rst       <= (nxt == NEXT) || (abort && !abort_q);
         busy          <= (nxt == INIT) || (nxt == W_INIT) || (nxt == SHUF) || (nxt == W_SHUF) ||
                          (nxt == DEC)  || (nxt == W_DEC)  || (nxt == NEXT);
         case (nxt)
            INIT, W_INIT: s_sel <= 2'd0;
            SHUF, W_SHUF: s_sel <= 2'd1;
            DEC,  W_DEC:  s_sel <= 2'd2;
            default:      s_sel <= 2'd3;
         endcase

         if (load) begin
            found      <= 1'b0;
            exhausted  <= 1'b0;
            secret_key <= KEY_FIRST;
            keys_tried <= '0;
         end else begin
            if (nxt == FOUND)     found     <= 1'b1;
            if (nxt == EXHAUSTED) exhausted <= 1'b1;
            if (st == NEXT && !abort) begin
               if (keys_tried != '1)       keys_tried <= keys_tried + 1'b1;
               if (secret_key != KEY_LAST) secret_key <= secret_key + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: randomized sub-FSM responder plus a key-outcome model.
module tb_rc4_key_search_ctrl;
   localparam int KW   = 24;
   localparam int LAST = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, abort = 1'b0;
   logic          init_done = 1'b0, shuffle_done = 1'b0, decrypt_done = 1'b0, fail_sig = 1'b0;
   logic          init_start, shuffle_start, decrypt_start, sub_rst;
   logic [1:0]    s_sel;
   logic [KW-1:0] secret_key, keys_tried;
   logic          busy, found, exhausted;

   int n_chk = 0, n_fail = 0;
   int pass_key = -1;
   bit both_on_fail = 1'b0, slow_shuf = 1'b0;
   int init_cnt = -1, shuf_cnt = -1, dec_cnt = -1;
   int exp_phase = 0;
   int n_init = 0, n_shuf = 0, n_dec = 0, n_sub = 0;

   rc4_key_search_ctrl #(.KEY_W(KW), .KEY_FIRST(24'd0), .KEY_LAST(24'(LAST))) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .init_done(init_done), .shuffle_done(shuffle_done), .decrypt_done(decrypt_done),
      .fail_sig(fail_sig), .init_start(init_start), .shuffle_start(shuffle_start),
      .decrypt_start(decrypt_start), .sub_rst(sub_rst), .s_sel(s_sel),
      .secret_key(secret_key), .keys_tried(keys_tried), .busy(busy),
      .found(found), .exhausted(exhausted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sub-FSM responder: answers each start pulse after a random delay, injects stray pulses.
   initial forever begin
      @(negedge clk);
      init_done = 1'b0; shuffle_done = 1'b0; decrypt_done = 1'b0; fail_sig = 1'b0;
      if (!rst || abort || sub_rst) begin
         if (rst && sub_rst) begin
            n_sub++;
            chk("sub_rst s_sel", s_sel, 2'd3);
         end
         init_cnt = -1; shuf_cnt = -1; dec_cnt = -1; exp_phase = 0;
      end else begin
         if (init_start) begin
            chk("init order", exp_phase, 0);
            chk("init s_sel", s_sel, 2'd0);
            chk("init busy", busy, 1'b1);
            exp_phase = 1; n_init++;
            init_cnt = $urandom_range(0, 4);
         end else if (init_cnt == 0) begin
            init_done = 1'b1; init_cnt = -1;
         end else if (init_cnt > 0) init_cnt--;

         if (shuffle_start) begin
            chk("shuf order", exp_phase, 1);
            chk("shuf s_sel", s_sel, 2'd1);
            exp_phase = 2; n_shuf++;
            shuf_cnt = (slow_shuf && secret_key == 7) ? 40 : $urandom_range(0, 4);
         end else if (shuf_cnt == 0) begin
            shuffle_done = 1'b1; shuf_cnt = -1;
         end else if (shuf_cnt > 0) begin
            shuf_cnt--;
            if ($urandom_range(0, 3) == 0) begin
               init_done    = 1'b1;
               decrypt_done = 1'($urandom_range(0, 1));
               fail_sig     = 1'($urandom_range(0, 1));
            end
         end

         if (decrypt_start) begin
            chk("dec order", exp_phase, 2);
            chk("dec s_sel", s_sel, 2'd2);
            exp_phase = 0; n_dec++;
            dec_cnt = $urandom_range(0, 4);
         end else if (dec_cnt == 0) begin
            dec_cnt = -1;
            if (secret_key == pass_key) decrypt_done = 1'b1;
            else begin
               fail_sig     = 1'b1;
               decrypt_done = both_on_fail | 1'($urandom_range(0, 1));
            end
         end else if (dec_cnt > 0) dec_cnt--;
      end
   end

   task automatic wait_end();
      int c;
      c = 0;
      while (!(found || exhausted) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk("search timeout", found || exhausted, 1'b1);
   endtask

   // Model: keys below pass_key are rejected; pass_key beyond the range means exhaustion.
   task automatic run(input int pk);
      pass_key = pk;
      n_init = 0; n_shuf = 0; n_dec = 0; n_sub = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_end();
      if (pk >= 0 && pk <= LAST) begin
         chk("found", found, 1'b1);
         chk("exhausted", exhausted, 1'b0);
         chk("key", secret_key, pk);
         chk("keys_tried", keys_tried, pk);
         chk("n_sub_rst", n_sub, pk);
         chk("n_init", n_init, pk + 1);
         chk("n_dec", n_dec, pk + 1);
      end else begin
         chk("found", found, 1'b0);
         chk("exhausted", exhausted, 1'b1);
         chk("key", secret_key, LAST);
         chk("keys_tried", keys_tried, LAST + 1);
         chk("n_sub_rst", n_sub, LAST + 1);
         chk("n_shuf", n_shuf, LAST + 1);
      end
      chk("end busy", busy, 1'b0);
      chk("end s_sel", s_sel, 2'd3);
      repeat (3) @(negedge clk);
      chk("sticky key", secret_key, (pk >= 0 && pk <= LAST) ? pk : LAST);
      chk("sticky flag", found | exhausted, 1'b1);
   endtask

   initial begin
      int c;
      #3 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst busy", busy, 1'b0);
      chk("rst found", found, 1'b0);
      chk("rst exhausted", exhausted, 1'b0);
      chk("rst s_sel", s_sel, 2'd3);
      chk("rst key", secret_key, 0);
      chk("rst tried", keys_tried, 0);
      chk("rst starts", {init_start, shuffle_start, decrypt_start, sub_rst}, 4'd0);
      rst = 1'b1;

      run(0);
      chk("single init", n_init, 1);
      chk("single shuf", n_shuf, 1);
      run(5);
      run(-1);
      both_on_fail = 1'b1;
      run(3);
      both_on_fail = 1'b0;

      // Abort from FOUND keeps the result.
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort found kept", found, 1'b1);
      chk("abort key kept", secret_key, 3);
      chk("abort sub_rst", sub_rst, 1'b1);
      @(negedge clk);
      chk("abort sub_rst width", sub_rst, 1'b0);

      // Abort in W_SHUF at key 7.
      slow_shuf = 1'b1; pass_key = 9;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 0;
      while (!(secret_key == 7 && s_sel == 2'd1 && !shuffle_start) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk("reach key7 shuf", secret_key, 7);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort busy", busy, 1'b0);
      chk("abort s_sel", s_sel, 2'd3);
      chk("abort sub_rst2", sub_rst, 1'b1);
      chk("abort key7", secret_key, 7);
      chk("abort tried", keys_tried, 7);
      chk("abort no found", found, 1'b0);
      repeat (3) @(negedge clk);
      chk("abort idle", busy, 1'b0);
      slow_shuf = 1'b0;
      run(2);

      repeat (8) run($urandom_range(0, LAST + 3));

      // Reset mid-search returns to IDLE and waits for a new start.
      pass_key = -1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst busy", busy, 1'b0);
      chk("midrst key", secret_key, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("post rst idle", busy, 1'b0);
      chk("post rst no start", init_start, 1'b0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
